// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM for the MIPS-subset datapath.
// Moore machine: each state decodes the datapath strobes, mux selects and the
// aluop code for the ALU-control decoder. Opcodes without a handler raise the
// sticky illegal flag and return to FETCH.
module mc_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [1:0] aluop,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    state_t state_reg, state_next;
    logic   illegal_reg, illegal_next;
    logic   pc_write;
    logic   pc_write_cond;

    // State register and sticky illegal flag; reset aborts any instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEMADR.
    always_comb begin
        state_next   = S_FETCH;
        illegal_next = illegal_reg;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEMADR;
                else if (opcode == OP_RTYPE)            state_next = S_EXEC;
                else if (opcode == OP_BEQ)              state_next = S_BRANCH;
                else if (opcode == OP_J)                state_next = S_JUMP;
                else if (opcode == OP_ADDI)             state_next = S_ADDIEX;
                else begin
                    state_next   = S_FETCH;
                    illegal_next = 1'b1;
                end
            end
            S_MEMADR:  state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXEC:    state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Moore output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        aluop         = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    aluop     = 2'b01;
                end
                S_RTYPEWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    aluop         = 2'b10;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Branch commits the PC only when the ALU reports equality.
    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign illegal = illegal_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: each instruction pushes its expected
// per-cycle state/output records, which are popped and compared every cycle.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic [1:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    int vectors    = 0;
    int miscompares = 0;
    logic exp_illegal = 1'b0;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] outs;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    wire [15:0] act_outs = {aluop, alu_src_a, alu_src_b, pc_source, pc_en, iord,
                            mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                            reg_write, instr_done};

    mc_main_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .aluop      (aluop),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference output table, one row per state code.
    function automatic logic [15:0] exp_outs(input logic [3:0] s, input logic z);
        logic [1:0] a_op, src_b, pc_src;
        logic src_a, pce, io, mr, mw, irw, rd, m2r, rw, dn;
        {a_op, src_b, pc_src} = '0;
        {src_a, pce, io, mr, mw, irw, rd, m2r, rw, dn} = '0;
        case (s)
            4'd0:  begin mr = 1; irw = 1; src_b = 2'b01; pce = 1; end
            4'd1:  src_b = 2'b11;
            4'd2:  begin src_a = 1; src_b = 2'b10; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin m2r = 1; rw = 1; dn = 1; end
            4'd5:  begin mw = 1; io = 1; dn = 1; end
            4'd6:  begin src_a = 1; a_op = 2'b01; end
            4'd7:  begin rd = 1; rw = 1; dn = 1; end
            4'd8:  begin src_a = 1; a_op = 2'b10; pce = z; pc_src = 2'b01; dn = 1; end
            4'd9:  begin pce = 1; pc_src = 2'b10; dn = 1; end
            4'd10: begin src_a = 1; src_b = 2'b10; end
            4'd11: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {a_op, src_a, src_b, pc_src, pce, io, mr, mw, irw, rd, m2r, rw, dn};
    endfunction

    // Runs one instruction from FETCH. Entry/exit: 1 time unit after a posedge
    // with the DUT in FETCH. seq holds n state codes, first in the low nibble.
    task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                             input int n, input logic [23:0] seq, input bit scramble);
        exp_t e;
        int bad;
        bad = miscompares;
        opcode = op;
        for (int i = 0; i < n; i++) begin
            e.st   = seq[4*i +: 4];
            e.outs = exp_outs(seq[4*i +: 4], z);
            e.ill  = exp_illegal;
            sb.push_back(e);
        end
        if (op != 6'b000000 && op != 6'b100011 && op != 6'b101011 &&
            op != 6'b000100 && op != 6'b000010 && op != 6'b001000)
            exp_illegal = 1'b1;
        for (int i = 0; i < n; i++) begin
            zero = z;
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (state !== e.st) begin
                miscompares++;
                $display("FAIL %s cyc%0d state: got %0d expected %0d", name, i, state, e.st);
            end
            vectors++;
            if (act_outs !== e.outs) begin
                miscompares++;
                $display("FAIL %s cyc%0d outputs: got %b expected %b", name, i, act_outs, e.outs);
            end
            vectors++;
            if (illegal !== e.ill) begin
                miscompares++;
                $display("FAIL %s cyc%0d illegal: got %b expected %b", name, i, illegal, e.ill);
            end
            @(posedge clk);
            #1;
            // Past MEMADR the opcode must no longer influence the sequence.
            if (scramble && i >= 2) opcode = 6'($urandom);
        end
        $display("%s op=%b zero=%b cycles=%0d errors=%0d", name, op, z, n, miscompares - bad);
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'b100011; zero = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (state !== 4'd0 || act_outs !== 16'd0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got state=%0d outs=%b ill=%b expected 0/0/0", state, act_outs, illegal);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_illegal = 1'b0;
        $display("reset released");
    endtask

    task automatic test_lw();
        run_instr("lw", 6'b100011, 1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_instr("rtype", 6'b000000, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b0);
        run_instr("sw",    6'b101011, 1'b0, 4, {8'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b1);
    endtask

    task automatic test_beq();
        run_instr("beq_taken",    6'b000100, 1'b1, 3, {12'd0, 4'd8, 4'd1, 4'd0}, 1'b0);
        run_instr("beq_nottaken", 6'b000100, 1'b0, 3, {12'd0, 4'd8, 4'd1, 4'd0}, 1'b0);
    endtask

    task automatic test_j_addi();
        run_instr("j",    6'b000010, 1'b0, 3, {12'd0, 4'd9, 4'd1, 4'd0}, 1'b0);
        run_instr("addi", 6'b001000, 1'b0, 4, {8'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op",  6'b111111, 1'b0, 2, {16'd0, 4'd1, 4'd0}, 1'b0);
        run_instr("lw_after_ill", 6'b100011, 1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_clear: got %b expected 0", illegal);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_illegal = 1'b0;
        run_instr("lw_after_clr", 6'b100011, 1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0);
    endtask

    task automatic test_reset_mid_exec();
        run_instr("rtype_partial", 6'b000000, 1'b0, 2, {16'd0, 4'd1, 4'd0}, 1'b0);
        @(negedge clk);
        vectors++;
        if (state !== 4'd6) begin
            miscompares++;
            $display("FAIL in_exec: got state %0d expected 6", state);
        end
        zero = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd0 || act_outs !== 16'd0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_exec: got state=%0d outs=%b ill=%b expected 0/0/0", state, act_outs, illegal);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_illegal = 1'b0;
        run_instr("rtype_after_rst", 6'b000000, 1'b0, 4, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b0);
    endtask

    initial begin
        rst = 1'b1; opcode = 6'd0; zero = 1'b0;
        test_reset();
        test_lw();
        test_back_to_back();
        test_beq();
        test_j_addi();
        test_illegal();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
